sparc_ram_responder: RTL and testbench

- Memory-side responder for the control unit's RAM handshake.
- Accepts RAM_enable and RAM_OpCode (SPARC op3), an address and store data.
- Performs big-endian byte, halfword or word accesses on an internal byte array.
- Signals completion to the control unit on MFC, returning formatted load data or an error flag.

---
 rtl/sparc_mem_pkg.sv | 44 ++++
 rtl/sparc_load_align.sv | 34 +++
 rtl/sparc_ram_responder.sv | 169 ++++++++++++++++
 tb/tb_sparc_ram_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_mem_pkg.sv
// Shared op3 codes, state/size encodings and decode helpers for the RAM
// responder and its load formatter.
package sparc_mem_pkg;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    // Unsupported op3 values report word size; they are flagged as errors anyway.
    function automatic size_e op_size(input logic [5:0] op3);
        case (op3)
            OP_LDUB, OP_LDSB, OP_STB: op_size = SZ_B;
            OP_LDUH, OP_LDSH, OP_STH: op_size = SZ_H;
            default:                  op_size = SZ_W;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [5:0] op3);
        op_is_load = (op3 == OP_LD)   || (op3 == OP_LDUB) || (op3 == OP_LDUH) ||
                     (op3 == OP_LDSB) || (op3 == OP_LDSH);
    endfunction

    function automatic logic op_is_store(input logic [5:0] op3);
        op_is_store = (op3 == OP_ST) || (op3 == OP_STB) || (op3 == OP_STH);
    endfunction

endpackage

// File: rtl/sparc_load_align.sv
// Formats the four big-endian bytes read at A..A+3 into a load result and
// reports the access size and whether the address is misaligned for it.
module sparc_load_align
    import sparc_mem_pkg::*;
(
    input  logic [7:0]  byte0,
    input  logic [7:0]  byte1,
    input  logic [7:0]  byte2,
    input  logic [7:0]  byte3,
    input  logic [1:0]  addr_lo,
    input  logic [5:0]  op3,
    output logic [31:0] load_data,
    output logic [1:0]  size,
    output logic        misaligned
);

    size_e sz;

    always_comb begin
        sz         = op_size(op3);
        size       = sz;
        misaligned = ((sz == SZ_W) && (addr_lo != 2'b00)) ||
                     ((sz == SZ_H) && addr_lo[0]);
        case (op3)
            OP_LD:   load_data = {byte0, byte1, byte2, byte3};
            OP_LDUB: load_data = {24'd0, byte0};
            OP_LDSB: load_data = {{24{byte0[7]}}, byte0};
            OP_LDUH: load_data = {16'd0, byte0, byte1};
            OP_LDSH: load_data = {{16{byte0[7]}}, byte0, byte1};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/sparc_ram_responder.sv
// Memory-side responder for the control unit's RAM_enable/MFC handshake,
// backed by a big-endian byte array with wrap-around addressing.
module sparc_ram_responder
    import sparc_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 512,
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        RAM_enable,
    input  logic [5:0]  RAM_OpCode,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        MEM_ERR,
    output logic        BUSY
);

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [5:0]             op_q, op_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            dout_q, dout_d;
    logic                   mfc_q, mfc_d;
    logic                   err_q, err_d;

    logic [7:0]             mem_q [DEPTH_BYTES];
    logic [ADDR_BITS-1:0]   lane_addr [4];
    logic [7:0]             rd_byte   [4];
    logic [7:0]             lane_data [4];
    logic [3:0]             lane_en;
    logic                   wr_en;

    logic [31:0]            load_data;
    logic [1:0]             size_w;
    logic                   misaligned;
    logic                   access_err;

    logic                   unused_addr_hi;
    assign unused_addr_hi = ^Address[31:ADDR_BITS];

    // Lane i always maps to A+i; the narrow address width gives the wrap for free.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = addr_q + ADDR_BITS'(i);
            rd_byte[i]   = mem_q[lane_addr[i]];
        end
    end

    sparc_load_align u_load_align (
        .byte0      (rd_byte[0]),
        .byte1      (rd_byte[1]),
        .byte2      (rd_byte[2]),
        .byte3      (rd_byte[3]),
        .addr_lo    (addr_q[1:0]),
        .op3        (op_q),
        .load_data  (load_data),
        .size       (size_w),
        .misaligned (misaligned)
    );

    assign access_err = misaligned || !(op_is_load(op_q) || op_is_store(op_q));

    always_comb begin
        lane_en = 4'b0000;
        for (int i = 0; i < 4; i++) lane_data[i] = 8'd0;
        case (size_w)
            SZ_B: begin
                lane_en      = 4'b0001;
                lane_data[0] = wdata_q[7:0];
            end
            SZ_H: begin
                lane_en      = 4'b0011;
                lane_data[0] = wdata_q[15:8];
                lane_data[1] = wdata_q[7:0];
            end
            default: begin
                lane_en      = 4'b1111;
                lane_data[0] = wdata_q[31:24];
                lane_data[1] = wdata_q[23:16];
                lane_data[2] = wdata_q[15:8];
                lane_data[3] = wdata_q[7:0];
            end
        endcase
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (RAM_enable) begin
                    op_d    = RAM_OpCode;
                    addr_d  = Address[ADDR_BITS-1:0];
                    wdata_d = DataIn;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d   = access_err;
                    dout_d  = (!access_err && op_is_load(op_q)) ? load_data : 32'd0;
                    wr_en   = !access_err && op_is_store(op_q);
                    mfc_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!RAM_enable) begin
                    mfc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 6'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            dout_q  <= 32'd0;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the byte array has no reset; reset holds state_q in IDLE, which keeps wr_en low.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && lane_en[i]) mem_q[lane_addr[i]] <= lane_data[i];
        end
    end

    assign DataOut = dout_q;
    assign MFC     = mfc_q;
    assign MEM_ERR = err_q;
    assign BUSY    = (state_q == ST_BUSY);

endmodule

// File: tb/tb_sparc_ram_responder.sv
// Self-checking bench: directed vector table, handshake/reset sequences and
// randomized accesses against a byte-array reference model.
module tb_sparc_ram_responder;

    localparam int DEPTH    = 512;
    localparam int WAIT     = 2;
    localparam int LATENCY  = WAIT + 1;
    localparam int MAX_WAIT = 40;

    localparam logic [5:0] LD = 6'o00, LDUB = 6'o01, LDUH = 6'o02, LDSB = 6'o11,
                           LDSH = 6'o12, ST = 6'o04, STB = 6'o05, STH = 6'o06,
                           LDD = 6'o03, STD = 6'o07, SWAP = 6'o17;

    logic        Clk = 1'b0;
    logic        RESET = 1'b1;
    logic        RAM_enable = 1'b0;
    logic [5:0]  RAM_OpCode = 6'd0;
    logic [31:0] Address = 32'd0;
    logic [31:0] DataIn = 32'd0;
    logic [31:0] DataOut;
    logic        MFC, MEM_ERR, BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_mem [DEPTH];

    sparc_ram_responder #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_BITS   (9),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .Clk        (Clk),
        .RESET      (RESET),
        .RAM_enable (RAM_enable),
        .RAM_OpCode (RAM_OpCode),
        .Address    (Address),
        .DataIn     (DataIn),
        .DataOut    (DataOut),
        .MFC        (MFC),
        .MEM_ERR    (MEM_ERR),
        .BUSY       (BUSY)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Reference: size from the op, alignment by modulo, big-endian byte assembly.
    task automatic model_access(input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] din, output logic [31:0] exp_d,
                                output logic exp_e);
        int nbytes = 1;
        bit ok = 1, is_ld = 0, sgn = 0;
        int a = int'(addr % 32'(DEPTH));
        longint val = 0;
        case (op)
            LD:      begin nbytes = 4; is_ld = 1; end
            LDUB:    begin nbytes = 1; is_ld = 1; end
            LDUH:    begin nbytes = 2; is_ld = 1; end
            LDSB:    begin nbytes = 1; is_ld = 1; sgn = 1; end
            LDSH:    begin nbytes = 2; is_ld = 1; sgn = 1; end
            ST:      nbytes = 4;
            STB:     nbytes = 1;
            STH:     nbytes = 2;
            default: ok = 0;
        endcase
        exp_d = 32'd0;
        exp_e = 1'b0;
        if (!ok || (a % nbytes) != 0) begin
            exp_e = 1'b1;
            return;
        end
        if (is_ld) begin
            for (int k = 0; k < nbytes; k++) val = val * 256 + longint'(model_mem[(a + k) % DEPTH]);
            if (sgn && val >= (longint'(1) << (8 * nbytes - 1))) val -= (longint'(1) << (8 * nbytes));
            exp_d = 32'(val);
        end else begin
            for (int k = 0; k < nbytes; k++) model_mem[(a + k) % DEPTH] = 8'(din >> (8 * (nbytes - 1 - k)));
        end
    endtask

    // One full handshake: request, bounded wait for MFC, release, MFC must drop.
    task automatic access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] din,
                          output logic [31:0] d, output logic e, output int lat);
        @(negedge Clk);
        RAM_enable = 1'b1;
        RAM_OpCode = op;
        Address    = addr;
        DataIn     = din;
        @(posedge Clk);
        #1;
        lat = 0;
        while (!MFC && lat < MAX_WAIT) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        d = DataOut;
        e = MEM_ERR;
        @(negedge Clk);
        RAM_enable = 1'b0;
        @(posedge Clk);
        #1;
        check("mfc_release", {31'd0, MFC}, 32'd0);
        check("dout_hold_after_release", DataOut, d);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] d, md;
        logic        e, me;
        int          lat, n;
        logic [5:0]  rops [12];

        #3 RESET = 1'b0;
        #2;
        check("reset_dout", DataOut, 32'd0);
        check("reset_mfc", {31'd0, MFC}, 32'd0);
        check("reset_err", {31'd0, MEM_ERR}, 32'd0);
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        repeat (2) @(negedge Clk);
        RESET = 1'b1;

        for (int w = 0; w < DEPTH / 4; w++) begin
            logic [31:0] r;
            r = $urandom;
            access(ST, 32'(w * 4), r, d, e, lat);
            model_access(ST, 32'(w * 4), r, md, me);
            check("fill_err", {31'd0, e}, 32'd0);
        end

        vecs.push_back('{ST,   32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0});
        vecs.push_back('{LD,   32'h010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{LDUB, 32'h011, 32'h0,        32'h000000AD, 1'b0});
        vecs.push_back('{LDSB, 32'h011, 32'h0,        32'hFFFFFFAD, 1'b0});
        vecs.push_back('{LDUH, 32'h012, 32'h0,        32'h0000BEEF, 1'b0});
        vecs.push_back('{LDSH, 32'h012, 32'h0,        32'hFFFFBEEF, 1'b0});
        vecs.push_back('{STB,  32'h013, 32'h12345677, 32'h00000000, 1'b0});
        vecs.push_back('{LD,   32'h010, 32'h0,        32'hDEADBE77, 1'b0});
        vecs.push_back('{LDSB, 32'h013, 32'h0,        32'h00000077, 1'b0});
        vecs.push_back('{STH,  32'h010, 32'h0000CAFE, 32'h00000000, 1'b0});
        vecs.push_back('{LD,   32'h010, 32'h0,        32'hCAFEBE77, 1'b0});
        vecs.push_back('{LD,   32'h012, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{LDD,  32'h010, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{STH,  32'h011, 32'hFFFFFFFF, 32'h00000000, 1'b1});
        vecs.push_back('{ST,   32'h012, 32'hFFFFFFFF, 32'h00000000, 1'b1});
        vecs.push_back('{SWAP, 32'h010, 32'hFFFFFFFF, 32'h00000000, 1'b1});
        vecs.push_back('{LD,   32'h010, 32'h0,        32'hCAFEBE77, 1'b0});
        vecs.push_back('{LD,   32'h210, 32'h0,        32'hCAFEBE77, 1'b0});
        vecs.push_back('{LDUH, 32'hFFFF_FE10, 32'h0,  32'h0000CAFE, 1'b0});

        foreach (vecs[i]) begin
            access(vecs[i].op, vecs[i].addr, vecs[i].din, d, e, lat);
            model_access(vecs[i].op, vecs[i].addr, vecs[i].din, md, me);
            check($sformatf("vec%0d_dout", i), d, vecs[i].exp_d);
            check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_e});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LATENCY));
        end

        // Level held high after MFC: completion holds and no second access starts.
        model_access(LD, 32'h10, 32'h0, md, me);
        @(negedge Clk);
        RAM_enable = 1'b1;
        RAM_OpCode = LD;
        Address    = 32'h10;
        @(posedge Clk);
        #1;
        lat = 0;
        while (!MFC && lat < MAX_WAIT) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        check("hold_latency", 32'(lat), 32'(LATENCY));
        for (int c = 0; c < 10; c++) begin
            @(posedge Clk);
            #1;
            check($sformatf("hold%0d_mfc", c), {31'd0, MFC}, 32'd1);
            check($sformatf("hold%0d_busy", c), {31'd0, BUSY}, 32'd0);
            check($sformatf("hold%0d_dout", c), DataOut, md);
        end
        @(negedge Clk);
        RAM_enable = 1'b0;
        @(posedge Clk);
        #1;
        check("hold_mfc_fall", {31'd0, MFC}, 32'd0);
        check("hold_dout_kept", DataOut, md);

        // Reset while a store is in BUSY: aborted, nothing written.
        @(negedge Clk);
        RAM_enable = 1'b1;
        RAM_OpCode = ST;
        Address    = 32'h20;
        DataIn     = 32'h11111111;
        @(posedge Clk);
        #1;
        check("abort_in_busy", {31'd0, BUSY}, 32'd1);
        @(negedge Clk);
        RAM_enable = 1'b0;
        RESET = 1'b0;
        #1;
        check("abort_mfc", {31'd0, MFC}, 32'd0);
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_dout", DataOut, 32'd0);
        repeat (3) @(negedge Clk);
        RESET = 1'b1;
        access(LD, 32'h20, 32'h0, d, e, lat);
        model_access(LD, 32'h20, 32'h0, md, me);
        check("abort_no_write", d, md);
        check("abort_no_write_err", {31'd0, e}, 32'd0);

        rops = '{LD, LDUB, LDUH, LDSB, LDSH, ST, STB, STH, LDD, STD, SWAP, 6'h3F};
        n = 0;
        repeat (250) begin
            logic [5:0]  op;
            logic [31:0] a, din;
            op  = rops[$urandom_range(0, 11)];
            a   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFE3) : $urandom;
            din = $urandom;
            access(op, a, din, d, e, lat);
            model_access(op, a, din, md, me);
            check($sformatf("rnd%0d_dout op=%02h a=%08h", n, op, a), d, md);
            check($sformatf("rnd%0d_err op=%02h a=%08h", n, op, a), {31'd0, e}, {31'd0, me});
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(LATENCY));
            n++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
